// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: one shared BCD decoder, active-low digit enables, frame-synchronous updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module ssd_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int DIV_WIDTH = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  input  logic [3:0]  digit_en,
  output logic [3:0]  bcd_sel,
  output logic [3:0]  ssd_ctl,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    SEL_D0 = 2'd0,
    SEL_D1 = 2'd1,
    SEL_D2 = 2'd2,
    SEL_D3 = 2'd3
  } sel_e;

  localparam logic [DIV_WIDTH-1:0] PRESC_MAX = DIV_WIDTH'(SCAN_DIV - 1);

  sel_e                 sel_q, sel_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [15:0]          disp_q, disp_d;
  logic [15:0]          pend_q, pend_d;
  logic                 pending_q, pending_d;
  logic [3:0]           ssd_q, ssd_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 bnd_q, fs_q;

  logic                 tick;
  logic                 boundary;
  logic                 accept;
  logic [1:0]           sel_idx;
  logic [3:0]           nib;
  logic [3:0]           lz_blank;
  logic                 shown;

  // Handshake: upd_ready is high whenever no word is waiting for a frame
  // boundary; a word transfers on any cycle where upd_valid && upd_ready.
  assign upd_ready = ~pending_q;
  assign accept    = upd_valid & ~pending_q;

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (sel_q == SEL_D3);
  assign sel_idx  = sel_q;
  assign nib      = disp_q[{sel_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = (disp_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (disp_q[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (disp_q[7:4] == 4'd0);
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
    sel_d   = sel_q;
    if (tick) begin
      case (sel_q)
        SEL_D0:  sel_d = SEL_D1;
        SEL_D1:  sel_d = SEL_D2;
        SEL_D2:  sel_d = SEL_D3;
        default: sel_d = SEL_D0;
      endcase
    end
  end

  // A commit and an accept never coincide: accept needs pending_q low, commit needs it high.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      pend_d    = upd_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    shown = digit_en[sel_idx] & ~lz_blank[sel_idx];
    ssd_d = shown ? ~(4'b0001 << sel_idx) : 4'b1111;
    bcd_d = shown ? nib : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      sel_q     <= SEL_D0;
      disp_q    <= 16'h0000;
      pend_q    <= 16'h0000;
      pending_q <= 1'b0;
      ssd_q     <= 4'b1111;
      bcd_q     <= 4'd0;
      bnd_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      sel_q     <= sel_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      ssd_q     <= ssd_d;
      bcd_q     <= bcd_d;
      // Two stages so the pulse lines up with the first registered D0 output.
      bnd_q     <= boundary;
      fs_q      <= bnd_q;
    end
  end

  assign ssd_ctl     = ssd_q;
  assign bcd_sel     = bcd_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized scoreboard bench for ssd_scan_ctrl with SCAN_DIV=4; model is time-indexed from reset release.
// Honours LEADING_ZERO_BLANK_EN if the build defines it.
module tb_ssd_scan_ctrl;
  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0000;
  logic        upd_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  bcd_sel;
  logic [3:0]  ssd_ctl;
  logic        frame_start;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.SCAN_DIV(SD), .DIV_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_data    (upd_data),
    .upd_ready   (upd_ready),
    .digit_en    (digit_en),
    .bcd_sel     (bcd_sel),
    .ssd_ctl     (ssd_ctl),
    .frame_start (frame_start)
  );

  int checks   = 0;
  int failures = 0;

  // Expected {ssd_ctl, bcd_sel, frame_start, upd_ready} for the coming cycle.
  logic [9:0] exp_q[$];

  int          m        = 0;
  bit          has_pend = 1'b0;
  logic [15:0] pend_w   = 16'h0000;
  logic [15:0] disp_w   = 16'h0000;

  function automatic bit lz_off(input logic [15:0] d, input int s);
`ifdef LEADING_ZERO_BLANK_EN
    return (s != 0) && ((d >> (4 * s)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // m counts cycles since reset release; digit slot s = (m/SD)%4, frames every FRAME cycles.
  always @(posedge clk) begin : model
    int          s;
    bit          show, fs_e, bnd, hp;
    logic [3:0]  ssd_e, bcd_e;
    logic [15:0] dw, pw;
    if (rst) begin
      m        <= 0;
      has_pend <= 1'b0;
      disp_w   <= 16'h0000;
      pend_w   <= 16'h0000;
      exp_q.push_back({4'hF, 4'h0, 1'b0, 1'b1});
    end else begin
      s     = (m / SD) % 4;
      dw    = disp_w;
      pw    = pend_w;
      hp    = has_pend;
      show  = digit_en[s] && !lz_off(dw, s);
      ssd_e = show ? ~(4'b0001 << s) : 4'hF;
      bcd_e = show ? dw[4*s +: 4] : 4'h0;
      fs_e  = (m >= 1) && (((m - 1) % FRAME) == FRAME - 1);
      bnd   = (m % FRAME) == FRAME - 1;
      if (bnd && hp) begin
        dw = pw;
        hp = 1'b0;
      end else if (upd_valid && !hp) begin
        pw = upd_data;
        hp = 1'b1;
      end
      exp_q.push_back({ssd_e, bcd_e, fs_e, !hp});
      m        <= m + 1;
      has_pend <= hp;
      disp_w   <= dw;
      pend_w   <= pw;
    end
  end

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({ssd_ctl, bcd_sel, frame_start, upd_ready} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got ssd=%b bcd=%h fs=%b rdy=%b exp ssd=%b bcd=%h fs=%b rdy=%b",
                 $time, ssd_ctl, bcd_sel, frame_start, upd_ready, e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    bit took;
    took      = 1'b0;
    upd_valid = 1'b1;
    upd_data  = w;
    for (int k = 0; k < 200 && !took; k++) begin
      took = upd_ready;
      cyc(1);
    end
    upd_valid = 1'b0;
    checks++;
    if (!took) begin
      failures++;
      $display("FAIL send_timeout word=%h got ready=0 for 200 cycles required accept", w);
    end
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if ((m % FRAME) == ph && upd_ready) hit = 1'b1;
      else cyc(1);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL phase_timeout phase=%0d got no ready slot required one within 200 cycles", ph);
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(40);

    send(16'h1234);
    send(16'h9999);
    cyc(40);

    wait_phase(FRAME - 1);
    upd_valid = 1'b1;
    upd_data  = 16'h5678;
    cyc(1);
    upd_valid = 1'b0;
    cyc(40);

    digit_en = 4'b1011;
    cyc(40);
    digit_en = 4'hF;

    send(16'h0070);
    cyc(40);
    send(16'h0000);
    cyc(40);
    send(16'hABCD);
    cyc(40);

    repeat (40) begin
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cyc($urandom_range(0, 20));
      send(16'($urandom));
    end
    cyc(40);

    wait_phase(0);
    send(16'h4321);
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(40);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
